// File: rtl/anffl_tex_etc1_encoder_pkg.sv
// ETC1 encoder shared definitions.
// States, modifier table, block layout, error math.
package anffl_tex_pkg;

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_AVG    = 3'd1;
  localparam logic [2:0] ST_SEARCH = 3'd2;
  localparam logic [2:0] ST_INDEX  = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;

  localparam int ERR_W = 13;

  localparam int OFS_R    = 0;
  localparam int OFS_B    = 8;
  localparam int OFS_G    = 16;
  localparam int OFS_FLIP = 24;
  localparam int OFS_DIFF = 25;
  localparam int OFS_CW1  = 26;
  localparam int OFS_CW0  = 29;
  localparam int OFS_IDX  = 32;

  function automatic logic [7:0] etc1_mod(
    logic [2:0] t, logic mag);
    logic [7:0] m;
    case (t)
      3'd0:    m = mag ? 8'd8   : 8'd2;
      3'd1:    m = mag ? 8'd17  : 8'd5;
      3'd2:    m = mag ? 8'd29  : 8'd9;
      3'd3:    m = mag ? 8'd42  : 8'd13;
      3'd4:    m = mag ? 8'd60  : 8'd18;
      3'd5:    m = mag ? 8'd80  : 8'd24;
      3'd6:    m = mag ? 8'd106 : 8'd33;
      default: m = mag ? 8'd183 : 8'd47;
    endcase
    return m;
  endfunction

  // 4-bit base from an 8-texel channel sum
  function automatic logic [3:0] q4(logic [10:0] sum);
    logic [11:0] v;
    v = 12'(sum[10:3]) * 12'd15 + 12'd128;
    return v[11:8];
  endfunction

  function automatic logic [9:0] chan_err(
    logic [7:0] b, logic [7:0] px,
    logic [2:0] t, logic [1:0] c);
    logic signed [9:0] m, r, d;
    m = $signed({2'b00, etc1_mod(t, c[0])});
    r = c[1] ? $signed({2'b00, b}) - m
             : $signed({2'b00, b}) + m;
    if (r < 10'sd0) r = 10'sd0;
    else if (r > 10'sd255) r = 10'sd255;
    d = r - $signed({2'b00, px});
    return d[9] ? 10'(-d) : 10'(d);
  endfunction

  function automatic logic [9:0] cand_err(
    logic [23:0] b, logic [23:0] px,
    logic [2:0] t, logic [1:0] c);
    return chan_err(b[23:16], px[23:16], t, c)
         + chan_err(b[15:8], px[15:8], t, c)
         + chan_err(b[7:0], px[7:0], t, c);
  endfunction

endpackage

// File: rtl/anffl_tex_etc1_encoder_if.sv
// Texel-in / block-out handshake bundle.
// Master is the source/sink side, slave the encoder.
interface anffl_tex_etc1_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_texel;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;
  logic        busy;

  modport master (
    output in_valid, in_texel, out_ready,
    input  in_ready, out_valid, out_block, busy
  );

  modport slave (
    input  in_valid, in_texel, out_ready,
    output in_ready, out_valid, out_block, busy
  );
endinterface

// File: rtl/anffl_tex_etc1_texel_err.sv
// Best ETC1 code for one texel under one table.
// Ties resolve to the lowest code.
module anffl_tex_etc1_texel_err
  import anffl_tex_pkg::*;
(
  input  logic [23:0] base_i,
  input  logic [23:0] texel_i,
  input  logic [2:0]  tbl_i,
  output logic [1:0]  code_o,
  output logic [9:0]  err_o
);

  logic [9:0] e0, e1, e2, e3;

  assign e0 = cand_err(base_i, texel_i, tbl_i, 2'd0);
  assign e1 = cand_err(base_i, texel_i, tbl_i, 2'd1);
  assign e2 = cand_err(base_i, texel_i, tbl_i, 2'd2);
  assign e3 = cand_err(base_i, texel_i, tbl_i, 2'd3);

  // strict compare keeps the earlier code on ties
  always_comb begin
    code_o = 2'd0;
    err_o  = e0;
    if (e1 < err_o) begin
      code_o = 2'd1;
      err_o  = e1;
    end
    if (e2 < err_o) begin
      code_o = 2'd2;
      err_o  = e2;
    end
    if (e3 < err_o) begin
      code_o = 2'd3;
      err_o  = e3;
    end
  end

endmodule

// File: rtl/anffl_tex_etc1_encoder.sv
// Streaming ETC1 (individual, flip=0) encoder.
// Load 16 texels, search 8 tables, emit block.
module anffl_tex_etc1_encoder
  import anffl_tex_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  anffl_tex_etc1_encoder_if.slave bus
);

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q;
  logic [23:0]      tex_q [16];
  logic [10:0]      sum_q [2][3];
  logic [23:0]      base_q [2];
  logic [2:0]       t_q, k_q;
  logic [ERR_W-1:0] acc_q [2];
  logic [ERR_W-1:0] acc_d [2];
  logic [ERR_W-1:0] best_q [2];
  logic [2:0]       bt_q [2];
  logic             ov_q;
  logic [63:0]      blk_q;
  logic [1:0]       code [2];
  logic [9:0]       err [2];
  logic [3:0]       pos [2];
  logic             acc_in;

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.busy      = (state_q != ST_LOAD);
  assign bus.out_valid = ov_q;
  assign bus.out_block = blk_q;
  assign acc_in        = bus.in_valid & bus.in_ready;

  for (genvar s = 0; s < 2; s++) begin : g_sb
    localparam logic SB = 1'(s);
    anffl_tex_etc1_texel_err u_err (
      .base_i (base_q[s]),
      .texel_i(tex_q[{k_q[2:1], SB, k_q[0]}]),
      .tbl_i  ((state_q == ST_INDEX) ? bt_q[s] : t_q),
      .code_o (code[s]),
      .err_o  (err[s])
    );
    // index slot p = 4y + (3-x), i.e. {y, ~x}
    assign pos[s]   = {k_q[2:1], ~SB, ~k_q[0]};
    assign acc_d[s] = acc_q[s] + ERR_W'(err[s]);
  end

  // sequencing: load, avg, 64 search, 8 index, out
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:
        if (acc_in && cnt_q == 4'd15) state_d = ST_AVG;
      ST_AVG:
        state_d = ST_SEARCH;
      ST_SEARCH:
        if (t_q == 3'd7 && k_q == 3'd7) state_d = ST_INDEX;
      ST_INDEX:
        if (k_q == 3'd7) state_d = ST_OUT;
      ST_OUT:
        if (ov_q && bus.out_ready) state_d = ST_LOAD;
      default:
        state_d = ST_LOAD;
    endcase
  end

  // datapath: sums, base, table search, index pack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
      k_q     <= '0;
      ov_q    <= 1'b0;
      blk_q   <= '0;
      for (int i = 0; i < 16; i++) tex_q[i] <= '0;
      for (int s = 0; s < 2; s++) begin
        base_q[s] <= '0;
        acc_q[s]  <= '0;
        best_q[s] <= '1;
        bt_q[s]   <= '0;
        for (int c = 0; c < 3; c++) sum_q[s][c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ov_q    <= (state_q == ST_OUT) && !(ov_q && bus.out_ready);
      case (state_q)
        ST_LOAD: if (acc_in) begin
          tex_q[cnt_q] <= bus.in_texel;
          cnt_q <= cnt_q + 4'd1;
          for (int c = 0; c < 3; c++)
            sum_q[cnt_q[1]][c] <= sum_q[cnt_q[1]][c]
                                + 11'(bus.in_texel[8*c +: 8]);
        end
        ST_AVG: begin
          for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 3; c++) begin
              base_q[s][8*c +: 8] <= {2{q4(sum_q[s][c])}};
              sum_q[s][c] <= '0;
            end
            acc_q[s]  <= '0;
            best_q[s] <= '1;
            bt_q[s]   <= '0;
          end
          t_q <= '0;
          k_q <= '0;
          blk_q[OFS_R +: 8] <= {q4(sum_q[0][2]), q4(sum_q[1][2])};
          blk_q[OFS_G +: 8] <= {q4(sum_q[0][1]), q4(sum_q[1][1])};
          blk_q[OFS_B +: 8] <= {q4(sum_q[0][0]), q4(sum_q[1][0])};
          blk_q[OFS_DIFF]   <= 1'b0;
          blk_q[OFS_FLIP]   <= 1'b0;
        end
        ST_SEARCH: begin
          for (int s = 0; s < 2; s++) begin
            if (k_q == 3'd7) begin
              acc_q[s] <= '0;
              if (acc_d[s] < best_q[s]) begin
                best_q[s] <= acc_d[s];
                bt_q[s]   <= t_q;
              end
            end else begin
              acc_q[s] <= acc_d[s];
            end
          end
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) t_q <= t_q + 3'd1;
        end
        ST_INDEX: begin
          for (int s = 0; s < 2; s++)
            blk_q[OFS_IDX + int'({pos[s], 1'b0}) +: 2] <= code[s];
          blk_q[OFS_CW0 +: 3] <= bt_q[0];
          blk_q[OFS_CW1 +: 3] <= bt_q[1];
          k_q <= k_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anffl_tex_etc1_encoder.sv
// Directed + random bench for the ETC1 encoder.
// Reference computes the block from the format rules.
module tb_anffl_tex_etc1_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  anffl_tex_etc1_encoder_if bus ();

  anffl_tex_etc1_encoder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  int SMALL [8] = '{2, 5, 9, 13, 18, 24, 33, 47};
  int LARGE [8] = '{8, 17, 29, 42, 60, 80, 106, 183};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int chan(logic [23:0] px, int ch);
    return int'(px[8*ch +: 8]);
  endfunction

  function automatic int recon(int base, int t, int c);
    int m, v;
    m = c[0] ? LARGE[t] : SMALL[t];
    v = c[1] ? base - m : base + m;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  // error of texel px under base b[3], table t, code c
  function automatic int terr(int b0, int b1, int b2,
                              logic [23:0] px, int t, int c);
    int e, d;
    int b [3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    e = 0;
    for (int ch = 0; ch < 3; ch++) begin
      d = recon(b[ch], t, c) - chan(px, ch);
      e += (d < 0) ? -d : d;
    end
    return e;
  endfunction

  function automatic bit in_sb(int i, int s);
    return ((i % 4) / 2) == s;
  endfunction

  function automatic void ref_encode(input logic [23:0] px [16],
                                     output logic [63:0] blk,
                                     output int emin [2]);
    int q [2][3];
    int sum, best, bt, tot, e, be, bc, p, x, y;
    blk = '0;
    for (int s = 0; s < 2; s++) begin
      for (int ch = 0; ch < 3; ch++) begin
        sum = 0;
        for (int i = 0; i < 16; i++)
          if (in_sb(i, s)) sum += chan(px[i], ch);
        q[s][ch] = ((sum / 8) * 15 + 128) / 256;
      end
      best = 1 << 30;
      bt = 0;
      for (int t = 0; t < 8; t++) begin
        tot = 0;
        for (int i = 0; i < 16; i++) begin
          if (!in_sb(i, s)) continue;
          be = 1 << 30;
          for (int c = 0; c < 4; c++) begin
            e = terr(q[s][0] * 17, q[s][1] * 17, q[s][2] * 17,
                     px[i], t, c);
            if (e < be) be = e;
          end
          tot += be;
        end
        if (tot < best) begin
          best = tot;
          bt = t;
        end
      end
      emin[s] = best;
      for (int i = 0; i < 16; i++) begin
        if (!in_sb(i, s)) continue;
        be = 1 << 30;
        bc = 0;
        for (int c = 0; c < 4; c++) begin
          e = terr(q[s][0] * 17, q[s][1] * 17, q[s][2] * 17,
                   px[i], bt, c);
          if (e < be) begin
            be = e;
            bc = c;
          end
        end
        x = i % 4;
        y = i / 4;
        p = 4 * y + 3 - x;
        blk[32 + 2 * p] = bc[0];
        blk[33 + 2 * p] = bc[1];
      end
      if (s == 0) blk[31:29] = bt[2:0];
      else blk[28:26] = bt[2:0];
    end
    blk[7:0]   = {q[0][2][3:0], q[1][2][3:0]};
    blk[15:8]  = {q[0][0][3:0], q[1][0][3:0]};
    blk[23:16] = {q[0][1][3:0], q[1][1][3:0]};
  endfunction

  // decode subblock s of blk and sum its error against px
  function automatic int decode_err(logic [63:0] blk,
                                    logic [23:0] px [16], int s);
    int qr, qg, qb, t, c, p, e;
    qr = (s == 0) ? int'(blk[7:4])   : int'(blk[3:0]);
    qb = (s == 0) ? int'(blk[15:12]) : int'(blk[11:8]);
    qg = (s == 0) ? int'(blk[23:20]) : int'(blk[19:16]);
    t  = (s == 0) ? int'(blk[31:29]) : int'(blk[28:26]);
    e = 0;
    for (int i = 0; i < 16; i++) begin
      if (!in_sb(i, s)) continue;
      p = 4 * (i / 4) + 3 - (i % 4);
      c = {30'd0, blk[33 + 2 * p], blk[32 + 2 * p]};
      e += terr(qb * 17, qg * 17, qr * 17, px[i], t, c);
    end
    return e;
  endfunction

  task automatic send_only(input logic [23:0] px [16]);
    int n;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_texel = px[i];
      n = 0;
      while (!bus.in_ready && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 300) chk("in_ready timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [23:0] px [16],
                           input string tag,
                           output logic [63:0] blk);
    int n;
    send_only(px);
    n = 0;
    while (!bus.out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, 74);
    blk = bus.out_block;
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk({tag, " pulse"}, bus.out_valid, 0);
      chk({tag, " ready back"}, bus.in_ready, 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] px [16];
    logic [63:0] blk, held, exp;
    int emin [2];
    int cnt, mode;

    bus.in_valid  = 1'b0;
    bus.in_texel  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_block", bus.out_block, 0);
    chk("rst busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) px[i] = 24'h808080;
    run_block(px, "gray", blk);
    chk("gray block", blk, 64'hFFFFFFFF_00888888);

    for (int i = 0; i < 16; i++)
      px[i] = ((i % 4) < 2) ? 24'h000000 : 24'hFFFFFF;
    run_block(px, "split", blk);
    chk("split block", blk, 64'hA0A0A0A0_000F0F0F);

    // back-pressure: hold for 10 cycles, junk on input
    for (int i = 0; i < 16; i++) px[i] = 24'($urandom);
    ref_encode(px, exp, emin);
    bus.out_ready = 1'b0;
    run_block(px, "hold", held);
    chk("hold block", held, exp);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_texel = 24'($urandom);
      @(posedge clk); #1;
      chk("hold valid", bus.out_valid, 1);
      chk("hold stable", bus.out_block, held);
      chk("hold in_ready", bus.in_ready, 0);
      chk("hold busy", bus.busy, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold accept", bus.out_valid, 0);
    chk("hold ready back", bus.in_ready, 1);
    for (int i = 0; i < 16; i++) px[i] = 24'h808080;
    run_block(px, "after hold", blk);
    chk("after hold block", blk, 64'hFFFFFFFF_00888888);

    // reset after 7 texels discards the partial block
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_texel = 24'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midload rst busy", bus.busy, 0);
    chk("midload rst ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) px[i] = 24'h808080;
    run_block(px, "post rst", blk);
    chk("post rst block", blk, 64'hFFFFFFFF_00888888);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt++;
    end
    chk("post rst extra out", cnt, 0);

    // reset mid-search drops the block
    for (int i = 0; i < 16; i++) px[i] = 24'($urandom);
    send_only(px);
    repeat (30) @(posedge clk);
    #1;
    chk("search busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("search rst out_valid", bus.out_valid, 0);
    chk("search rst block", bus.out_block, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt++;
    end
    chk("search rst dropped", cnt, 0);
    chk("search rst idle", bus.busy, 0);

    // random blocks against the reference
    for (int b = 0; b < 360; b++) begin
      mode = b % 4;
      for (int i = 0; i < 16; i++) begin
        case (mode)
          0: px[i] = {8'($urandom_range(0, 2) * 127 + 1),
                      8'($urandom_range(0, 2) * 127),
                      8'($urandom_range(0, 2) * 127)};
          1: px[i] = {8'(100 + $urandom_range(0, 12)),
                      8'(50 + $urandom_range(0, 12)),
                      8'(200 + $urandom_range(0, 12))};
          default: px[i] = 24'($urandom);
        endcase
      end
      ref_encode(px, exp, emin);
      run_block(px, "rand", blk);
      chk("rand block", blk, exp);
      chk("rand err sb0", decode_err(blk, px, 0), emin[0]);
      chk("rand err sb1", decode_err(blk, px, 1), emin[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
